// File: rtl/sys_defs.sv
// Shared definitions for the fetch front end: default widths, reset PC and the
// fetch sequencer state encoding.
package sys_defs;

  localparam int          DEFAULT_XLEN     = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    MISS   = 2'd1,
    SQUASH = 2'd2,
    HOLD   = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC priority mux: EX branch beats ROB recovery, and any redirect
// overrides the predictor, which in turn overrides sequential PC+4.
module fetch_pc_sel #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] cur_pc_i,
  input  logic            certain_req_i,
  input  logic [XLEN-1:0] certain_pc_i,
  input  logic            rob_req_i,
  input  logic [XLEN-1:0] rob_pc_i,
  input  logic            pred_req_i,
  input  logic [XLEN-1:0] pred_pc_i,
  output logic            redir_o,
  output logic [XLEN-1:0] redir_pc_o,
  output logic [XLEN-1:0] npc_o
);

  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

  assign redir_o    = certain_req_i | rob_req_i;
  assign redir_pc_o = (certain_req_i ? certain_pc_i : rob_pc_i) & WORD_MASK;
  assign npc_o      = pred_req_i ? (pred_pc_i & WORD_MASK) : (cur_pc_i + XLEN'(4));

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: drives the Icache request, rides out misses, drops responses
// belonging to squashed requests and parks one instruction during backend stalls.
module fetch_ctrl
  import sys_defs::*;
#(
  parameter int              XLEN     = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            rob_stall,
  input  logic            certain_branch_req,
  input  logic [XLEN-1:0] certain_branch_pc,
  input  logic            rob_target_req,
  input  logic [XLEN-1:0] rob_target_pc,
  input  logic            branch_pred_req,
  input  logic [XLEN-1:0] branch_pred_pc,
  input  logic [63:0]     Icache2proc_data,
  input  logic            Icache2proc_data_valid,
  output logic            proc2Icache_req,
  output logic [XLEN-1:0] proc2Icache_addr,
  output logic            fetch_valid,
  output logic [XLEN-1:0] fetch_pc,
  output logic [XLEN-1:0] fetch_npc,
  output logic [31:0]     fetch_inst
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] miss_addr_q, miss_addr_d;
  logic [31:0]     hold_inst_q, hold_inst_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;

  logic            redir;
  logic [XLEN-1:0] redir_pc;
  logic [XLEN-1:0] npc;
  logic [XLEN-1:0] block_addr;
  logic [31:0]     cur_inst;

  logic            req_c, valid_c;
  logic [XLEN-1:0] addr_c, pc_c;
  logic [31:0]     inst_c;

  fetch_pc_sel #(.XLEN(XLEN)) u_pc_sel (
    .cur_pc_i      (pc_q),
    .certain_req_i (certain_branch_req),
    .certain_pc_i  (certain_branch_pc),
    .rob_req_i     (rob_target_req),
    .rob_pc_i      (rob_target_pc),
    .pred_req_i    (branch_pred_req),
    .pred_pc_i     (branch_pred_pc),
    .redir_o       (redir),
    .redir_pc_o    (redir_pc),
    .npc_o         (npc)
  );

  assign block_addr = pc_q & ~XLEN'(7);
  assign cur_inst   = pc_q[2] ? Icache2proc_data[63:32] : Icache2proc_data[31:0];

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path infers a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    miss_addr_d = miss_addr_q;
    hold_inst_d = hold_inst_q;
    hold_pc_d   = hold_pc_q;
    req_c       = 1'b0;
    addr_c      = block_addr;
    valid_c     = 1'b0;
    pc_c        = pc_q;
    inst_c      = cur_inst;

    unique case (state_q)
      FETCH: begin
        req_c = ~rob_stall;
        if (redir) begin
          pc_d = redir_pc;
        end else if (rob_stall) begin
          pc_d = pc_q;
        end else if (Icache2proc_data_valid) begin
          valid_c = 1'b1;
          pc_d    = npc;
        end else begin
          miss_addr_d = block_addr;
          state_d     = MISS;
        end
      end
      MISS: begin
        req_c  = 1'b1;
        addr_c = miss_addr_q;
        if (redir) begin
          pc_d    = redir_pc;
          state_d = SQUASH;
        end else if (Icache2proc_data_valid && !rob_stall) begin
          valid_c = 1'b1;
          pc_d    = npc;
          state_d = FETCH;
        end else if (Icache2proc_data_valid) begin
          hold_inst_d = cur_inst;
          hold_pc_d   = pc_q;
          state_d     = HOLD;
        end
      end
      SQUASH: begin
        // The in-flight miss must complete before a new address can be issued.
        req_c  = 1'b1;
        addr_c = miss_addr_q;
        if (redir)                  pc_d    = redir_pc;
        if (Icache2proc_data_valid) state_d = FETCH;
      end
      HOLD: begin
        pc_c   = hold_pc_q;
        inst_c = hold_inst_q;
        if (redir) begin
          pc_d    = redir_pc;
          state_d = FETCH;
        end else if (!rob_stall) begin
          valid_c = 1'b1;
          pc_d    = npc;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Everything visible to the Icache and ID is forced quiet while reset is held.
  assign proc2Icache_req  = reset & req_c;
  assign proc2Icache_addr = reset ? addr_c : '0;
  assign fetch_valid      = reset & valid_c;
  assign fetch_pc         = reset ? pc_c : '0;
  assign fetch_npc        = reset ? npc : '0;
  assign fetch_inst       = reset ? inst_c : '0;

  always_ff @(posedge clock) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch, and all state uses <=.
    if (!reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      miss_addr_q <= '0;
      hold_inst_q <= '0;
      hold_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      miss_addr_q <= miss_addr_d;
      hold_inst_q <= hold_inst_d;
      hold_pc_q   <= hold_pc_d;
    end
  end

endmodule
